// File: rtl/sy_ppl_bp_update.sv
// Commit-side branch-predictor training: queues BHT/BTB records from up to two
// resolved control-flow commits per cycle and drains one per cycle to fetch.

package sy_ppl_bp_pkg;
  localparam int AWTH = 32;

  typedef enum logic [2:0] {
    QD_OTHER     = 3'd0,
    QD_BRANCH    = 3'd1,
    QD_JUMP      = 3'd2,
    QD_JALR      = 3'd3,
    QD_CALL_JAL  = 3'd4,
    QD_CALL_JALR = 3'd5,
    QD_RET       = 3'd6
  } qdec_type_e;

  typedef struct packed {
    logic            vld;
    logic [AWTH-1:0] pc;
    logic            taken;
  } bht_update_t;

  typedef struct packed {
    logic            vld;
    logic [AWTH-1:0] pc;
    logic [AWTH-1:0] target_address;
  } btb_update_t;
endpackage

module sy_ppl_bp_update
  import sy_ppl_bp_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter int CWTH   = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [1:0]            cmt_vld_i,
  input  logic [1:0][AWTH-1:0]  cmt_pc_i,
  input  qdec_type_e [1:0]      cmt_type_i,
  input  logic [1:0]            cmt_is_c_i,
  input  logic [1:0]            cmt_taken_i,
  input  logic [1:0][AWTH-1:0]  cmt_target_i,
  input  logic [1:0][AWTH-1:0]  cmt_pred_npc_i,
  output logic                  cmt_rdy_o,
  output bht_update_t           bht_update_o,
  output btb_update_t           btb_update_o,
  output logic [CWTH-1:0]       br_cnt_o,
  output logic [CWTH-1:0]       mispred_cnt_o
);

  localparam int AW   = $clog2(QDEPTH);
  localparam int PTRW = AW + 1;

  typedef struct packed {
    logic            is_btb;
    logic [AWTH-1:0] pc;
    logic            taken;
    logic [AWTH-1:0] target;
  } entry_t;

  function automatic logic [CWTH-1:0] sat_add(input logic [CWTH-1:0] a,
                                              input logic [1:0]      b);
    logic [CWTH:0] s;
    s = {1'b0, a} + (CWTH+1)'(b);
    return s[CWTH] ? {CWTH{1'b1}} : s[CWTH-1:0];
  endfunction

  entry_t          r_q [QDEPTH];
  logic [PTRW-1:0] r_wptr;
  logic [PTRW-1:0] r_rptr;
  bht_update_t     r_bht;
  btb_update_t     r_btb;
  logic [CWTH-1:0] r_br_cnt;
  logic [CWTH-1:0] r_mis_cnt;

  logic [PTRW-1:0] w_occ;
  logic            w_rdy;
  logic [1:0]      w_acc;
  logic [1:0]      w_cf;
  logic [1:0]      w_mis;
  logic [1:0]      w_rec_vld;
  logic [AWTH-1:0] w_npc [2];
  entry_t          w_rec [2];
  entry_t          w_wdata0;
  entry_t          w_wdata1;
  logic            w_we0;
  logic            w_we1;
  logic [AW-1:0]   w_widx0;
  logic [AW-1:0]   w_widx1;
  logic [AW-1:0]   w_ridx;
  logic [1:0]      w_push_n;
  logic [1:0]      w_br_inc;
  logic [1:0]      w_mis_inc;

  // Readiness looks only at registered occupancy so it never depends on the pop.
  assign w_occ     = r_wptr - r_rptr;
  assign w_rdy     = (w_occ <= PTRW'(QDEPTH - 2));
  assign cmt_rdy_o = w_rdy;

  always_comb begin
    w_acc     = '0;
    w_cf      = '0;
    w_mis     = '0;
    w_rec_vld = '0;
    for (int i = 0; i < 2; i++) begin
      w_npc[i] = cmt_taken_i[i] ? cmt_target_i[i]
                                : cmt_pc_i[i] + (cmt_is_c_i[i] ? AWTH'(2) : AWTH'(4));
      w_rec[i]        = '0;
      w_rec[i].is_btb = (cmt_type_i[i] == QD_JALR) || (cmt_type_i[i] == QD_CALL_JALR);
      w_rec[i].pc     = cmt_pc_i[i];
      w_rec[i].taken  = cmt_taken_i[i];
      w_rec[i].target = cmt_target_i[i];
      w_acc[i]        = cmt_vld_i[i] && w_rdy;
      w_cf[i]         = w_acc[i] && (cmt_type_i[i] != QD_OTHER);
      w_mis[i]        = w_cf[i] && (w_npc[i] != cmt_pred_npc_i[i]);
      w_rec_vld[i]    = w_acc[i] && ((cmt_type_i[i] == QD_BRANCH) || w_rec[i].is_btb);
    end
  end

  // A lone record always lands at the head, whichever slot produced it.
  assign w_we0     = |w_rec_vld;
  assign w_we1     = &w_rec_vld;
  assign w_wdata0  = w_rec_vld[0] ? w_rec[0] : w_rec[1];
  assign w_wdata1  = w_rec[1];
  assign w_widx0   = r_wptr[AW-1:0];
  assign w_widx1   = r_wptr[AW-1:0] + AW'(1);
  assign w_ridx    = r_rptr[AW-1:0];
  assign w_push_n  = {1'b0, w_rec_vld[0]} + {1'b0, w_rec_vld[1]};
  assign w_br_inc  = {1'b0, w_cf[0]} + {1'b0, w_cf[1]};
  assign w_mis_inc = {1'b0, w_mis[0]} + {1'b0, w_mis[1]};

  always_ff @(posedge clk_i) begin
    if (w_we0) r_q[w_widx0] <= w_wdata0;
    if (w_we1) r_q[w_widx1] <= w_wdata1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr    <= '0;
      r_br_cnt  <= '0;
      r_mis_cnt <= '0;
    end else begin
      r_wptr    <= r_wptr + PTRW'(w_push_n);
      r_br_cnt  <= sat_add(r_br_cnt, w_br_inc);
      r_mis_cnt <= sat_add(r_mis_cnt, w_mis_inc);
    end
  end

  // Drain stage: the oldest entry moves into the update registers each cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rptr <= '0;
      r_bht  <= '0;
      r_btb  <= '0;
    end else if (w_occ != '0) begin
      r_rptr <= r_rptr + PTRW'(1);
      if (r_q[w_ridx].is_btb) begin
        r_btb.vld            <= 1'b1;
        r_btb.pc             <= r_q[w_ridx].pc;
        r_btb.target_address <= r_q[w_ridx].target;
        r_bht.vld            <= 1'b0;
      end else begin
        r_bht.vld   <= 1'b1;
        r_bht.pc    <= r_q[w_ridx].pc;
        r_bht.taken <= r_q[w_ridx].taken;
        r_btb.vld   <= 1'b0;
      end
    end else begin
      r_bht.vld <= 1'b0;
      r_btb.vld <= 1'b0;
    end
  end

  assign bht_update_o  = r_bht;
  assign btb_update_o  = r_btb;
  assign br_cnt_o      = r_br_cnt;
  assign mispred_cnt_o = r_mis_cnt;

endmodule

// File: tb/tb_sy_ppl_bp_update.sv
// Bench for sy_ppl_bp_update: directed tables and sequences plus random commits
// checked against a queue-based reference model.

module tb_sy_ppl_bp_update;
  import sy_ppl_bp_pkg::*;

  localparam int QD   = 4;
  localparam int CW   = 8;
  localparam int CMAX = 255;

  logic                 clk = 1'b0;
  logic                 rst_ni = 1'b1;
  logic [1:0]           vld;
  logic [1:0][AWTH-1:0] pc;
  qdec_type_e [1:0]     typ;
  logic [1:0]           isc;
  logic [1:0]           tkn;
  logic [1:0][AWTH-1:0] tgt;
  logic [1:0][AWTH-1:0] pred;
  logic                 rdy;
  bht_update_t          bht;
  btb_update_t          btb;
  logic [CW-1:0]        brc;
  logic [CW-1:0]        misc;

  always #5 clk = ~clk;

  sy_ppl_bp_update #(.QDEPTH(QD), .CWTH(CW)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .cmt_vld_i      (vld),
    .cmt_pc_i       (pc),
    .cmt_type_i     (typ),
    .cmt_is_c_i     (isc),
    .cmt_taken_i    (tkn),
    .cmt_target_i   (tgt),
    .cmt_pred_npc_i (pred),
    .cmt_rdy_o      (rdy),
    .bht_update_o   (bht),
    .btb_update_o   (btb),
    .br_cnt_o       (brc),
    .mispred_cnt_o  (misc)
  );

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic            btb;
    logic [AWTH-1:0] pc;
    logic            taken;
    logic [AWTH-1:0] tgt;
  } mrec_t;

  mrec_t           mq[$];
  int              m_br, m_mis;
  logic            e_bht_vld, e_bht_tkn, e_btb_vld;
  logic [AWTH-1:0] e_bht_pc, e_btb_pc, e_btb_tgt;

  typedef struct {
    qdec_type_e      t;
    logic [AWTH-1:0] p;
    logic            c;
    logic            k;
    logic [AWTH-1:0] g;
    logic [AWTH-1:0] pr;
    int              e_br;
    int              e_mis;
    int              e_rec;
  } row_t;

  row_t tbl[11];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_br = 0; m_mis = 0;
    e_bht_vld = 0; e_bht_tkn = 0; e_btb_vld = 0;
    e_bht_pc = '0; e_btb_pc = '0; e_btb_tgt = '0;
  endtask

  task automatic model_edge();
    bit    accept;
    mrec_t r;
    logic [AWTH-1:0] actual;
    accept = (mq.size() <= QD - 2);
    if (mq.size() > 0) begin
      r = mq.pop_front();
      if (r.btb) begin
        e_btb_vld = 1; e_btb_pc = r.pc; e_btb_tgt = r.tgt; e_bht_vld = 0;
      end else begin
        e_bht_vld = 1; e_bht_pc = r.pc; e_bht_tkn = r.taken; e_btb_vld = 0;
      end
    end else begin
      e_bht_vld = 0; e_btb_vld = 0;
    end
    if (accept) begin
      for (int i = 0; i < 2; i++) begin
        if (vld[i]) begin
          actual = tkn[i] ? tgt[i] : pc[i] + (isc[i] ? 32'd2 : 32'd4);
          if (typ[i] != QD_OTHER) begin
            m_br++;
            if (actual != pred[i]) m_mis++;
          end
          if (typ[i] == QD_BRANCH)
            mq.push_back('{btb: 1'b0, pc: pc[i], taken: tkn[i], tgt: '0});
          if (typ[i] == QD_JALR || typ[i] == QD_CALL_JALR)
            mq.push_back('{btb: 1'b1, pc: pc[i], taken: 1'b0, tgt: tgt[i]});
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("rdy", rdy, (mq.size() <= QD - 2));
    chk("bht_vld", bht.vld, e_bht_vld);
    if (e_bht_vld) begin
      chk("bht_pc", bht.pc, e_bht_pc);
      chk("bht_taken", bht.taken, e_bht_tkn);
    end
    chk("btb_vld", btb.vld, e_btb_vld);
    if (e_btb_vld) begin
      chk("btb_pc", btb.pc, e_btb_pc);
      chk("btb_tgt", btb.target_address, e_btb_tgt);
    end
    chk("br_cnt", brc, sat(m_br));
    chk("mis_cnt", misc, sat(m_mis));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic clear_in();
    vld = '0; pc = '0; isc = '0; tkn = '0; tgt = '0; pred = '0;
    typ[0] = QD_OTHER; typ[1] = QD_OTHER;
  endtask

  task automatic set_slot(input int s, input qdec_type_e t, input logic [AWTH-1:0] p,
                          input logic c, input logic k, input logic [AWTH-1:0] g,
                          input logic [AWTH-1:0] pr);
    vld[s] = 1'b1; typ[s] = t; pc[s] = p; isc[s] = c; tkn[s] = k; tgt[s] = g; pred[s] = pr;
  endtask

  // Asserts reset away from the clock edge, checks the async clear, releases mid-cycle.
  task automatic do_reset();
    clear_in();
    rst_ni = 1'b0;
    model_reset();
    #1;
    chk("rst_bht", bht, '0);
    chk("rst_btb", btb, '0);
    chk("rst_br", brc, 0);
    chk("rst_mis", misc, 0);
    chk("rst_rdy", rdy, 1);
    @(posedge clk);
    #4;
    rst_ni = 1'b1;
  endtask

  logic [AWTH-1:0] exp_pcs[4];
  int              tb_br, tb_mis;
  logic [AWTH-1:0] a;

  initial begin
    tbl[0]  = '{QD_BRANCH,    32'h100,      1'b0, 1'b1, 32'h80,  32'h80,       1, 0, 1};
    tbl[1]  = '{QD_BRANCH,    32'h100,      1'b0, 1'b0, 32'h80,  32'h80,       1, 1, 1};
    tbl[2]  = '{QD_BRANCH,    32'h200,      1'b1, 1'b0, 32'h0,   32'h202,      1, 0, 1};
    tbl[3]  = '{QD_JALR,      32'h300,      1'b0, 1'b1, 32'h400, 32'h400,      1, 0, 2};
    tbl[4]  = '{QD_CALL_JALR, 32'h300,      1'b0, 1'b1, 32'h500, 32'h304,      1, 1, 2};
    tbl[5]  = '{QD_JUMP,      32'h10,       1'b0, 1'b1, 32'h20,  32'h14,       1, 1, 0};
    tbl[6]  = '{QD_RET,       32'h10,       1'b0, 1'b1, 32'h40,  32'h40,       1, 0, 0};
    tbl[7]  = '{QD_OTHER,     32'h10,       1'b0, 1'b0, 32'h0,   32'h999,      0, 0, 0};
    tbl[8]  = '{QD_BRANCH,    32'hFFFFFFFE, 1'b1, 1'b0, 32'h0,   32'h0,        1, 0, 1};
    tbl[9]  = '{QD_CALL_JAL,  32'hFFFFFFFC, 1'b0, 1'b1, 32'h8,   32'h0,        1, 1, 0};
    tbl[10] = '{QD_JALR,      32'h7000,     1'b1, 1'b1, 32'h7002, 32'h7002,    1, 0, 2};

    clear_in();
    model_reset();
    #2;
    do_reset();

    // Single BRANCH into an empty queue
    set_slot(0, QD_BRANCH, 32'h1000, 1'b0, 1'b1, 32'h0F00, 32'h0F00);
    tick();
    chk("t1_br", brc, 1);
    chk("t1_mis", misc, 0);
    clear_in();
    tick();
    chk("t1_bht", {bht.vld, bht.pc, bht.taken}, {1'b1, 32'h1000, 1'b1});
    chk("t1_btbv", btb.vld, 0);

    // JALR + BRANCH in one cycle, drained in slot order
    do_reset();
    set_slot(0, QD_JALR, 32'h2000, 1'b0, 1'b1, 32'h3000, 32'h2004);
    set_slot(1, QD_BRANCH, 32'h3000, 1'b1, 1'b0, 32'h0, 32'h3002);
    tick();
    chk("t2_mis", misc, 1);
    chk("t2_br", brc, 2);
    clear_in();
    tick();
    chk("t2_btb", {btb.vld, btb.pc, btb.target_address}, {1'b1, 32'h2000, 32'h3000});
    chk("t2_bhtv0", bht.vld, 0);
    tick();
    chk("t2_bht", {bht.vld, bht.pc, bht.taken}, {1'b1, 32'h3000, 1'b0});
    chk("t2_btbv0", btb.vld, 0);

    // RET + CALL_JAL produce no records
    do_reset();
    set_slot(0, QD_RET, 32'h40, 1'b0, 1'b1, 32'h80, 32'h80);
    set_slot(1, QD_CALL_JAL, 32'h44, 1'b0, 1'b1, 32'h100, 32'h100);
    tick();
    clear_in();
    for (int i = 0; i < 3; i++) begin
      chk("t3_novld", {bht.vld, btb.vld}, 2'b00);
      tick();
    end
    chk("t3_br", brc, 2);

    // Single-slot vector table, alternating the producing slot
    do_reset();
    tb_br = 0; tb_mis = 0;
    for (int i = 0; i < 11; i++) begin
      clear_in();
      set_slot(i % 2, tbl[i].t, tbl[i].p, tbl[i].c, tbl[i].k, tbl[i].g, tbl[i].pr);
      tick();
      tb_br  += tbl[i].e_br;
      tb_mis += tbl[i].e_mis;
      chk("tbl_br", brc, tb_br);
      chk("tbl_mis", misc, tb_mis);
      clear_in();
      tick();
      chk("tbl_bhtv", bht.vld, (tbl[i].e_rec == 1));
      chk("tbl_btbv", btb.vld, (tbl[i].e_rec == 2));
      if (tbl[i].e_rec != 0) chk("tbl_pc", (tbl[i].e_rec == 1) ? bht.pc : btb.pc, tbl[i].p);
    end

    // Back-pressure: ready drops at occupancy 3, ignored slots are not counted
    do_reset();
    exp_pcs = '{32'hA0, 32'hA4, 32'hB0, 32'hB4};
    set_slot(0, QD_BRANCH, 32'hA0, 1'b0, 1'b1, 32'h50, 32'h50);
    set_slot(1, QD_BRANCH, 32'hA4, 1'b0, 1'b1, 32'h50, 32'h50);
    tick();
    chk("bp_rdy1", rdy, 1);
    set_slot(0, QD_BRANCH, 32'hB0, 1'b0, 1'b1, 32'h50, 32'h50);
    set_slot(1, QD_BRANCH, 32'hB4, 1'b0, 1'b1, 32'h50, 32'h50);
    tick();
    chk("bp_rdy0", rdy, 0);
    chk("bp_out0", {bht.vld, bht.pc}, {1'b1, exp_pcs[0]});
    set_slot(0, QD_BRANCH, 32'hC0, 1'b0, 1'b1, 32'h50, 32'h50);
    set_slot(1, QD_BRANCH, 32'hC4, 1'b0, 1'b1, 32'h50, 32'h50);
    tick();
    chk("bp_ign_br", brc, 4);
    chk("bp_rdy_back", rdy, 1);
    chk("bp_out1", {bht.vld, bht.pc}, {1'b1, exp_pcs[1]});
    clear_in();
    for (int i = 2; i < 4; i++) begin
      tick();
      chk("bp_out", {bht.vld, bht.pc}, {1'b1, exp_pcs[i]});
    end
    tick();
    chk("bp_empty", bht.vld, 0);

    // Counter saturation
    do_reset();
    for (int i = 0; i < 128; i++) begin
      set_slot(0, QD_JUMP, 32'h10, 1'b0, 1'b1, 32'h20, 32'h14);
      set_slot(1, QD_JUMP, 32'h30, 1'b0, 1'b1, 32'h60, 32'h34);
      tick();
      if (i == 126) chk("sat_254", misc, 8'd254);
    end
    chk("sat_mis", misc, 8'hFF);
    chk("sat_br", brc, 8'hFF);
    tick();
    chk("sat_hold", misc, 8'hFF);
    clear_in();
    tick();

    // Reset while three records are queued
    do_reset();
    for (int i = 0; i < 2; i++) begin
      set_slot(0, QD_BRANCH, 32'h800 + 32'(i * 8), 1'b0, 1'b0, 32'h0, 32'h0);
      set_slot(1, QD_JALR, 32'h804 + 32'(i * 8), 1'b0, 1'b1, 32'h900, 32'h900);
      tick();
    end
    clear_in();
    chk("mid_vld_pre", bht.vld, 1);
    chk("mid_rdy_pre", rdy, 0);
    #3;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_stale", {bht.vld, btb.vld}, 2'b00);
    end

    // Randomized commits against the model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      clear_in();
      for (int i = 0; i < 2; i++) begin
        vld[i] = ($urandom_range(0, 3) != 0);
        typ[i] = qdec_type_e'($urandom_range(0, 6));
        pc[i]  = {$urandom_range(0, 32'hFFFF), 1'b0} | 32'h8000_0000;
        isc[i] = 1'($urandom_range(0, 1));
        tkn[i] = 1'($urandom_range(0, 1));
        tgt[i] = {$urandom, 1'b0};
        a = tkn[i] ? tgt[i] : pc[i] + (isc[i] ? 32'd2 : 32'd4);
        pred[i] = ($urandom_range(0, 1) != 0) ? a : a + 32'd8;
      end
      tick();
    end
    clear_in();
    for (int n = 0; n < 6; n++) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
